// File: rtl/load_align_unit.sv
// Load alignment unit: issues one or two aligned bus reads per load, merges the
// beats of a word-crossing access and returns the selected bytes zero/sign-extended.
module load_align_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);
    localparam int B     = DATA_W / 8;
    localparam int OFF_W = $clog2(B);
    localparam int POS_W = OFF_W + 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT1 = 2'd1;
    localparam logic [1:0] BEAT2 = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [DATA_W-1:0] beat1_q, beat1_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [OFF_W-1:0]  off_q;
    logic [ADDR_W-1:0] base;
    logic              req_cross, req_illegal, cross_q;
    logic [DATA_W-1:0] low_beat, raw, ext;
    logic              sign_bit;

    function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [1:0] size);
        logic [POS_W-1:0] last;
        last = POS_W'(off) + (POS_W'(1) << size);
        return last > POS_W'(B);
    endfunction

    assign off_q       = addr_q[OFF_W-1:0];
    assign base        = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign cross_q     = crosses(off_q, size_q);
    assign req_cross   = crosses(req_addr[OFF_W-1:0], req_size);
    assign req_illegal = (DATA_W == 32) && (req_size == 2'd3);

    // In BEAT1 the live bus data is the low beat; in BEAT2 it becomes the high beat.
    assign low_beat = (state_q == BEAT1) ? bus_rdata : beat1_q;
    assign raw      = DATA_W'({bus_rdata, low_beat} >> {off_q, 3'b000});

    always_comb begin
        case (size_q)
            2'd0:    sign_bit = raw[7];
            2'd1:    sign_bit = raw[15];
            2'd2:    sign_bit = raw[31];
            default: sign_bit = raw[DATA_W-1];
        endcase
        sign_bit = sign_bit & ~unsigned_q;
        for (int i = 0; i < DATA_W; i++) begin
            ext[i] = (i < (8 << size_q)) ? raw[i] : sign_bit;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        beat1_d    = beat1_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    if (req_illegal || (req_cross && !MISALIGN_EN)) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = RESP;
                    end else begin
                        rsp_err_d = 1'b0;
                        state_d   = BEAT1;
                    end
                end
            end
            BEAT1: begin
                if (bus_ack) begin
                    beat1_d = bus_rdata;
                    if (cross_q) begin
                        state_d = BEAT2;
                    end else begin
                        rsp_data_d = ext;
                        state_d    = RESP;
                    end
                end
            end
            BEAT2: begin
                if (bus_ack) begin
                    rsp_data_d = ext;
                    state_d    = RESP;
                end
            end
            default: begin
                if (rsp_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            beat1_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            beat1_q    <= beat1_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign bus_req   = (state_q == BEAT1) || (state_q == BEAT2);
    assign bus_addr  = (state_q == BEAT1) ? base :
                       (state_q == BEAT2) ? base + ADDR_W'(B) : '0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule
